controlador_de_funcionalidade: RTL and testbench
================================================

CONTROLADOR_DE_FUNCIONALIDADE -- requirements
Module: controlador_de_funcionalidade

Interface
REQ-001 SHALL have parameter N_USERS, default 2, number of user request channels (2..8).
REQ-002 SHALL have parameter USER_W, default 3, user code width.
REQ-003 SHALL have parameter FUNC_W, default 3, function code width; function 0 = neutral/no request.
REQ-004 SHALL have parameter HOLD_CYCLES, default 4, cycles a granted function stays active (>=1).
REQ-005 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port REQ_VALID  input  N_USERS  per-user request, level-sensitive.
REQ-008 SHALL have port USER_CODE  input  N_USERS*USER_W  user i code at bits [i*USER_W +: USER_W].
REQ-009 SHALL have port FUNC  input  N_USERS*FUNC_W  user i function at bits [i*FUNC_W +: FUNC_W].
REQ-010 SHALL have port FUNC_ACTIVE  output  2**FUNC_W  bit f high while function f executes; bit 0 always 0.
REQ-011 SHALL have port GRANT  output  N_USERS  users whose function is executing.
REQ-012 SHALL have port DENIED  output  N_USERS  one-cycle pulse per user rejected at arbitration.
REQ-013 SHALL have port LOW_PRIO_USER  output  USER_W  code of the lowest-priority granted user.
REQ-014 SHALL have port AUTOPILOT  output  1  autopilot mode active.
REQ-015 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL classify codes: 3'b101 admin (rank 2); 3'b001, 3'b011, 3'b110 operator (rank 1); 3'b111 autopilot; any other code invalid (rank 0); for USER_W>3 the upper bits SHALL be 0 for a valid code.
REQ-017 SHALL permit admin any nonzero function; operator only functions 1..3; invalid users nothing.
REQ-018 SHALL implement states IDLE, ARBITRATE, ACTIVE, RELEASE, AUTO.
REQ-019 IDLE: when any REQ_VALID bit is high, SHALL register all codes/functions/valids into a snapshot and go to ARBITRATE next cycle; later input changes SHALL NOT affect that arbitration.
REQ-020 ARBITRATE: if every snapshot-valid user has code 3'b111 and at least two are valid, SHALL go to AUTO; otherwise SHALL evaluate all users in one cycle.
REQ-021 A user SHALL be a candidate if valid, nonzero function, and permitted; non-candidates that were valid SHALL get a DENIED pulse in the ARBITRATE cycle.
REQ-022 Candidates with distinct functions SHALL all be granted; among candidates with the same function only the highest rank wins, ties going to the lowest index; losers SHALL get a DENIED pulse.
REQ-023 With >=1 grant SHALL go to ACTIVE with hold counter = HOLD_CYCLES; with none SHALL go to RELEASE.
REQ-024 ACTIVE: GRANT and FUNC_ACTIVE SHALL be registered and constant; counter decrements each cycle; after exactly HOLD_CYCLES ACTIVE cycles SHALL go to RELEASE with GRANT/FUNC_ACTIVE cleared.
REQ-025 Requests arriving during ARBITRATE/ACTIVE/AUTO SHALL be ignored (no queueing).
REQ-026 RELEASE: SHALL wait until REQ_VALID is all zero, then return to IDLE the next cycle (no retrigger from a held request).
REQ-027 AUTO: AUTOPILOT=1, FUNC_ACTIVE=0, GRANT=0; SHALL exit to RELEASE when any REQ_VALID bit with code other than 3'b111 goes high, or when all REQ_VALID are low.
REQ-028 LOW_PRIO_USER SHALL be registered at ARBITRATE exit: lowest rank among granted users, ties going to the highest index; 0 when nothing is granted; held until the next arbitration or reset.
REQ-029 Hold counter width SHALL be $clog2(HOLD_CYCLES+1); no wrap-around permitted.

Reset
REQ-030 RST high SHALL force state IDLE, FUNC_ACTIVE=0, GRANT=0, DENIED=0, LOW_PRIO_USER=0, AUTOPILOT=0, BUSY=0, counter=0, snapshot cleared, immediately and regardless of CLK.
REQ-031 Reset in mid-ACTIVE or AUTO SHALL abort without any further DENIED pulse; after release, a held REQ_VALID SHALL be sampled as a fresh IDLE request.

Verification (N_USERS=2, HOLD_CYCLES=4)
REQ-032 Admin 101 func 1, operator 001 func 1 -> GRANT=01, DENIED[1] pulse, FUNC_ACTIVE[1]=1 for exactly 4 cycles, LOW_PRIO_USER=101.
REQ-033 Admin 101 func 2, operator 001 func 1 -> GRANT=11, FUNC_ACTIVE bits 1 and 2 set, LOW_PRIO_USER=001.
REQ-034 Both users 111 valid -> AUTOPILOT=1 from the cycle after ARBITRATE; drop both requests -> RELEASE, then IDLE, AUTOPILOT=0.
REQ-035 Operator 011 func 6, invalid 100 func 2 -> both DENIED pulse, GRANT=00, state RELEASE until REQ_VALID=00.
REQ-036 REQ_VALID held high through ACTIVE end -> no second grant until REQ_VALID drops for one cycle and rises again.
REQ-037 RST asserted mid-ACTIVE between clock edges -> all outputs 0 immediately, BUSY=0.

Source files
------------

// File: rtl/controlador_de_funcionalidade.sv
// Multi-user function arbiter: snapshot requests, arbitrate by rank and
// function, hold granted functions for a fixed time, or enter autopilot.
module controlador_de_funcionalidade #(
  parameter int N_USERS     = 2,
  parameter int USER_W      = 3,
  parameter int FUNC_W      = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_USERS-1:0]          REQ_VALID,
  input  logic [N_USERS*USER_W-1:0]   USER_CODE,
  input  logic [N_USERS*FUNC_W-1:0]   FUNC,
  output logic [(2**FUNC_W)-1:0]      FUNC_ACTIVE,
  output logic [N_USERS-1:0]          GRANT,
  output logic [N_USERS-1:0]          DENIED,
  output logic [USER_W-1:0]           LOW_PRIO_USER,
  output logic                        AUTOPILOT,
  output logic                        BUSY
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int NF    = 2**FUNC_W;
  localparam logic [USER_W-1:0] AUTO_CODE = USER_W'(3'b111);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ACTIVE,
    S_REL,
    S_AUTO
  } state_t;

  state_t                    state_q, state_d;
  logic [N_USERS-1:0]        snap_valid_q, snap_valid_d;
  logic [N_USERS*USER_W-1:0] snap_code_q, snap_code_d;
  logic [N_USERS*FUNC_W-1:0] snap_func_q, snap_func_d;
  logic [N_USERS-1:0]        grant_q, grant_d;
  logic [NF-1:0]             fa_q, fa_d;
  logic [USER_W-1:0]         lp_q, lp_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [N_USERS-1:0][1:0]        rank_a;
  logic [N_USERS-1:0][FUNC_W-1:0] func_a;
  logic [N_USERS-1:0][USER_W-1:0] code_a;
  logic [N_USERS-1:0]             cand_c, win_c, deny_c;
  logic [NF-1:0]                  fa_c;
  logic [USER_W-1:0]              lp_c;
  logic [1:0]                     min_r;
  logic                           all_auto, go_auto, auto_exit;
  int                             n_valid;

  function automatic logic [1:0] rank_of(input logic [USER_W-1:0] c);
    logic [1:0] r;
    r = 2'd0;
    if ((c >> 3) == '0) begin
      unique case (c[2:0])
        3'b101:                r = 2'd2;
        3'b001, 3'b011, 3'b110: r = 2'd1;
        default:               r = 2'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic permit(input logic [1:0] r,
                                  input logic [FUNC_W-1:0] f);
    logic p;
    p = 1'b0;
    if (f != '0) begin
      if (r == 2'd2)      p = 1'b1;
      else if (r == 2'd1) p = (32'(f) <= 32'd3);
    end
    return p;
  endfunction

  // Arbitration works purely on the snapshot so late input changes are inert
  always_comb begin
    rank_a   = '0;
    func_a   = '0;
    code_a   = '0;
    cand_c   = '0;
    win_c    = '0;
    fa_c     = '0;
    lp_c     = '0;
    min_r    = 2'd3;
    all_auto = 1'b1;
    n_valid  = 0;
    for (int i = 0; i < N_USERS; i++) begin
      code_a[i] = snap_code_q[i*USER_W +: USER_W];
      func_a[i] = snap_func_q[i*FUNC_W +: FUNC_W];
      rank_a[i] = rank_of(code_a[i]);
      cand_c[i] = snap_valid_q[i] && permit(rank_a[i], func_a[i]);
      if (snap_valid_q[i]) begin
        n_valid = n_valid + 1;
        if (code_a[i] != AUTO_CODE) all_auto = 1'b0;
      end
    end
    for (int i = 0; i < N_USERS; i++) begin
      win_c[i] = cand_c[i];
      for (int j = 0; j < N_USERS; j++) begin
        if (j != i && cand_c[j] && func_a[j] == func_a[i] &&
            (rank_a[j] > rank_a[i] ||
             (rank_a[j] == rank_a[i] && j < i)))
          win_c[i] = 1'b0;
      end
    end
    for (int i = 0; i < N_USERS; i++) begin
      if (win_c[i]) begin
        fa_c[func_a[i]] = 1'b1;
        if (rank_a[i] <= min_r) begin
          min_r = rank_a[i];
          lp_c  = code_a[i];
        end
      end
    end
    go_auto = all_auto && (n_valid >= 2);
  end

  assign deny_c = snap_valid_q & ~win_c;

  always_comb begin
    auto_exit = (REQ_VALID == '0);
    for (int i = 0; i < N_USERS; i++) begin
      if (REQ_VALID[i] && USER_CODE[i*USER_W +: USER_W] != AUTO_CODE)
        auto_exit = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_valid_d = snap_valid_q;
    snap_code_d  = snap_code_q;
    snap_func_d  = snap_func_q;
    grant_d      = grant_q;
    fa_d         = fa_q;
    lp_d         = lp_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID != '0) begin
          snap_valid_d = REQ_VALID;
          snap_code_d  = USER_CODE;
          snap_func_d  = FUNC;
          state_d      = S_ARB;
        end
      end
      S_ARB: begin
        if (go_auto) begin
          lp_d    = '0;
          grant_d = '0;
          fa_d    = '0;
          state_d = S_AUTO;
        end else begin
          lp_d = lp_c;
          if (win_c != '0) begin
            grant_d = win_c;
            fa_d    = fa_c;
            cnt_d   = CNT_W'(HOLD_CYCLES);
            state_d = S_ACTIVE;
          end else begin
            state_d = S_REL;
          end
        end
      end
      S_ACTIVE: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          grant_d = '0;
          fa_d    = '0;
          state_d = S_REL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_REL: begin
        if (REQ_VALID == '0) state_d = S_IDLE;
      end
      S_AUTO: begin
        if (auto_exit) state_d = S_REL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      snap_valid_q <= '0;
      snap_code_q  <= '0;
      snap_func_q  <= '0;
      grant_q      <= '0;
      fa_q         <= '0;
      lp_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      snap_valid_q <= snap_valid_d;
      snap_code_q  <= snap_code_d;
      snap_func_q  <= snap_func_d;
      grant_q      <= grant_d;
      fa_q         <= fa_d;
      lp_q         <= lp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign FUNC_ACTIVE   = fa_q;
  assign GRANT         = grant_q;
  assign DENIED        = (state_q == S_ARB && !go_auto) ? deny_c : '0;
  assign LOW_PRIO_USER = lp_q;
  assign AUTOPILOT     = (state_q == S_AUTO);
  assign BUSY          = (state_q != S_IDLE);

endmodule

// File: tb/tb_controlador_de_funcionalidade.sv
// Bench for controlador_de_funcionalidade: request-level model plus
// directed scenarios with hand-computed expectations.
module tb_controlador_de_funcionalidade;

  localparam int HOLD = 4;

  logic       CLK, RST;
  logic [1:0] rv;
  logic [5:0] uc, fn;
  logic [7:0] fa_o;
  logic [1:0] gr_o, den_o;
  logic [2:0] lp_o;
  logic       ap_o, busy_o;

  int checks = 0;
  int errors = 0;

  controlador_de_funcionalidade #(
    .N_USERS(2), .USER_W(3), .FUNC_W(3), .HOLD_CYCLES(HOLD)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(rv), .USER_CODE(uc), .FUNC(fn),
    .FUNC_ACTIVE(fa_o), .GRANT(gr_o), .DENIED(den_o),
    .LOW_PRIO_USER(lp_o), .AUTOPILOT(ap_o), .BUSY(busy_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Request-level model: the outcome of an arbitration is planned in full
  // when the request is captured, then played out phase by phase.
  function automatic int rank(input logic [2:0] c);
    case (c)
      3'd5:             return 2;
      3'd1, 3'd3, 3'd6: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic bit ok(input logic [2:0] c, input logic [2:0] f);
    if (f == 0) return 0;
    if (rank(c) == 2) return 1;
    if (rank(c) == 1) return f <= 3;
    return 0;
  endfunction

  int         ph, left, nv, best, bs, sc, bk, k;
  bit         allauto, ex;
  logic [1:0] o_grant, o_den;
  logic [7:0] o_fa;
  logic [2:0] o_lp;
  bit         o_auto;
  logic [1:0] e_grant, e_den;
  logic [7:0] e_fa;
  logic [2:0] e_lp;
  logic       e_auto, e_busy;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ph = 0; left = 0;
      e_grant = 0; e_den = 0; e_fa = 0; e_lp = 0; e_auto = 0; e_busy = 0;
    end else begin
      case (ph)
        0: if (rv != 0) begin
          nv = 0; allauto = 1;
          for (int i = 0; i < 2; i++)
            if (rv[i]) begin
              nv++;
              if (uc[i*3 +: 3] != 3'd7) allauto = 0;
            end
          o_auto = allauto && nv >= 2;
          o_grant = 0; o_fa = 0;
          for (int f = 1; f < 8; f++) begin
            best = -1; bs = -1;
            for (int i = 0; i < 2; i++)
              if (rv[i] && fn[i*3 +: 3] == f && ok(uc[i*3 +: 3], fn[i*3 +: 3])) begin
                sc = rank(uc[i*3 +: 3]) * 16 + (15 - i);
                if (sc > bs) begin bs = sc; best = i; end
              end
            if (best >= 0) begin o_grant[best] = 1; o_fa[f] = 1; end
          end
          o_den = rv & ~o_grant;
          o_lp = 0; bk = 1000;
          for (int i = 0; i < 2; i++)
            if (o_grant[i]) begin
              k = rank(uc[i*3 +: 3]) * 16 - i;
              if (k < bk) begin bk = k; o_lp = uc[i*3 +: 3]; end
            end
          ph = 1; e_busy = 1;
          e_den = o_auto ? 2'b00 : o_den;
        end
        1: begin
          e_den = 0;
          if (o_auto) begin
            ph = 4; e_auto = 1; e_lp = 0;
          end else begin
            e_lp = o_lp;
            if (o_grant != 0) begin
              ph = 2; left = HOLD; e_grant = o_grant; e_fa = o_fa;
            end else ph = 3;
          end
        end
        2: begin
          left--;
          if (left == 0) begin ph = 3; e_grant = 0; e_fa = 0; end
        end
        3: if (rv == 0) begin ph = 0; e_busy = 0; end
        4: begin
          ex = (rv == 0);
          for (int i = 0; i < 2; i++)
            if (rv[i] && uc[i*3 +: 3] != 3'd7) ex = 1;
          if (ex) begin ph = 3; e_auto = 0; end
        end
        default: ph = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("m_grant", gr_o, e_grant);
      chk("m_fa", fa_o, e_fa);
      chk("m_denied", den_o, e_den);
      chk("m_lp", lp_o, e_lp);
      chk("m_auto", ap_o, e_auto);
      chk("m_busy", busy_o, e_busy);
    end
  end

  task automatic go(input logic [1:0] v, input logic [2:0] c0,
                    input logic [2:0] f0, input logic [2:0] c1,
                    input logic [2:0] f1);
    @(negedge CLK);
    rv = v; uc = {c1, c0}; fn = {f1, f0};
  endtask

  initial begin
    RST = 1'b1; rv = 0; uc = 0; fn = 0;
    #3;
    chk("rst_grant", gr_o, 0);
    chk("rst_fa", fa_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_lp", lp_o, 0);
    @(negedge CLK); RST = 1'b0;

    // admin vs operator on the same function
    go(2'b11, 3'd5, 3'd1, 3'd1, 3'd1);
    @(negedge CLK);
    chk("s1_den", den_o, 2'b10);
    chk("s1_busy", busy_o, 1);
    rv = 0;
    @(negedge CLK);
    chk("s1_grant", gr_o, 2'b01);
    chk("s1_fa", fa_o, 8'h02);
    chk("s1_lp", lp_o, 3'd5);
    repeat (3) @(negedge CLK);
    chk("s1_fa_last", fa_o, 8'h02);
    @(negedge CLK);
    chk("s1_fa_end", fa_o, 8'h00);
    @(negedge CLK);
    chk("s1_idle", busy_o, 0);

    // distinct functions both granted
    go(2'b11, 3'd5, 3'd2, 3'd1, 3'd1);
    @(negedge CLK);
    @(negedge CLK);
    chk("s2_grant", gr_o, 2'b11);
    chk("s2_fa", fa_o, 8'h06);
    chk("s2_lp", lp_o, 3'd1);
    rv = 0;
    repeat (6) @(negedge CLK);
    chk("s2_idle", busy_o, 0);

    // autopilot, leaving by dropping requests
    go(2'b11, 3'd7, 3'd1, 3'd7, 3'd2);
    @(negedge CLK);
    chk("s3_arb_ap", ap_o, 0);
    @(negedge CLK);
    chk("s3_ap", ap_o, 1);
    chk("s3_grant", gr_o, 0);
    rv = 0;
    @(negedge CLK);
    chk("s3_rel_ap", ap_o, 0);
    chk("s3_rel_busy", busy_o, 1);
    @(negedge CLK);
    chk("s3_idle", busy_o, 0);

    // autopilot, leaving on a non-autopilot code
    go(2'b11, 3'd7, 3'd0, 3'd7, 3'd0);
    repeat (2) @(negedge CLK);
    chk("s3b_ap", ap_o, 1);
    uc = {3'd1, 3'd7};
    @(negedge CLK);
    chk("s3b_exit", ap_o, 0);
    rv = 0;
    @(negedge CLK);
    chk("s3b_idle", busy_o, 0);

    // nobody permitted
    go(2'b11, 3'd3, 3'd6, 3'd4, 3'd2);
    @(negedge CLK);
    chk("s4_den", den_o, 2'b11);
    @(negedge CLK);
    chk("s4_grant", gr_o, 0);
    chk("s4_den_off", den_o, 0);
    repeat (3) @(negedge CLK);
    chk("s4_rel_busy", busy_o, 1);
    rv = 0;
    @(negedge CLK);
    chk("s4_idle", busy_o, 0);

    // held request must not retrigger
    go(2'b01, 3'd5, 3'd3, 3'd0, 3'd0);
    repeat (2) @(negedge CLK);
    chk("s5_grant", gr_o, 2'b01);
    chk("s5_fa", fa_o, 8'h08);
    repeat (4) @(negedge CLK);
    chk("s5_end", gr_o, 0);
    repeat (3) @(negedge CLK);
    chk("s5_held_grant", gr_o, 0);
    chk("s5_held_busy", busy_o, 1);
    rv = 0;
    @(negedge CLK);
    chk("s5_idle", busy_o, 0);
    rv = 2'b01;
    @(negedge CLK);
    chk("s5_arb", gr_o, 0);
    @(negedge CLK);
    chk("s5_regrant", gr_o, 2'b01);
    rv = 0;
    repeat (6) @(negedge CLK);

    // equal rank tie goes to lowest index
    go(2'b11, 3'd5, 3'd4, 3'd5, 3'd4);
    @(negedge CLK);
    chk("s6_den", den_o, 2'b10);
    @(negedge CLK);
    chk("s6_grant", gr_o, 2'b01);
    chk("s6_fa", fa_o, 8'h10);
    rv = 0;
    repeat (6) @(negedge CLK);

    // lone autopilot code is just an invalid user
    go(2'b01, 3'd7, 3'd1, 3'd0, 3'd0);
    @(negedge CLK);
    chk("s7_den", den_o, 2'b01);
    @(negedge CLK);
    chk("s7_ap", ap_o, 0);
    rv = 0;
    repeat (3) @(negedge CLK);

    // asynchronous reset mid-ACTIVE, held request reused afterwards
    go(2'b01, 3'd5, 3'd1, 3'd0, 3'd0);
    repeat (2) @(negedge CLK);
    chk("s8_pre", gr_o, 2'b01);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("s8_grant", gr_o, 0);
    chk("s8_fa", fa_o, 0);
    chk("s8_busy", busy_o, 0);
    chk("s8_lp", lp_o, 0);
    chk("s8_den", den_o, 0);
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    chk("s8_rearb", busy_o, 1);
    @(negedge CLK);
    chk("s8_regrant", gr_o, 2'b01);
    rv = 0;
    repeat (6) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
